out_port_fifo: RTL and testbench
================================

# out_port_fifo

Output-port buffer downstream of the processor core's OUT path. It captures every 16-bit value the core writes to its output port and queues the values in a DEPTH-entry FIFO. An external consumer drains the queue with a valid/ready handshake, so a slow peripheral never loses OUT results while the core runs at full rate. It also mirrors the most recent written value and reports occupancy and overflow status.

## Interface
Parameters:
- DEPTH, 8, number of FIFO entries; a power of two, ≥ 2.
- WIDTH, 16, data width; matches the core output port.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- wr_en  input  1  core output-write strobe, one push per cycle when high.
- wr_data  input  WIDTH  value written by the core's OUT instruction.
- out_valid  output  1  head entry is present.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_data  output  WIDTH  head entry; 0 when empty.
- last_out  output  WIDTH  most recent wr_data seen with wr_en.
- count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set on a write while full with no pop.
- ovf_clr  input  1  synchronous clear of overflow.

## Operation
- Storage: DEPTH×WIDTH register array with a write pointer and a read pointer. Each pointer is $clog2(DEPTH) bits and wraps modulo DEPTH.
- Push: wr_en=1 and (not full or pop) → store wr_data at the write pointer, then increment the write pointer.
- Pop: out_valid=1 and out_ready=1 → increment the read pointer.
- out_data is driven combinationally from the entry at the read pointer (show-ahead). It is forced to 0 when empty.
- out_valid = not empty.
- Count update: push only +1; pop only −1; push and pop together, no change.
- Simultaneous push and pop when full: both happen, count stays DEPTH, overflow is not set.
- Simultaneous push and pop when empty: no pop occurs (out_valid=0), push happens, count becomes 1.
- Write while full with no pop: handled as set by the configuration (see Configuration). overflow is set to 1 in either build.
- overflow priority: a set event in the same cycle as ovf_clr wins. Otherwise ovf_clr=1 clears overflow to 0.
- last_out loads wr_data on every cycle with wr_en=1, including writes that are dropped.
- out_ready while empty is ignored; there is no pointer movement and no underflow.

## Timing
- Reset (rst=0, asynchronous) sets:
  - both pointers and count to 0;
  - empty=1, full=0, out_valid=0;
  - out_data=0, last_out=0, overflow=0.
- Array contents are not reset.
- Latency: a push at edge N makes out_valid=1 and out_data=wr_data from just after edge N. The value is consumable in the cycle after the write.
- Pop at edge N: the next entry (or 0 if now empty) appears on out_data just after edge N.
- A consumer holding out_ready=1 drains one entry per cycle.
- count, full, empty and overflow are registered or derived from registered state and change only after a clock edge or reset.
- Reset asserted mid-stream discards all queued entries immediately. The first push after rst is released starts at pointer 0.

## Configuration
- OUTPORT_DROP_OLDEST_EN defined: a write while full with no pop discards the oldest entry by advancing the read pointer, and stores the new value. count stays DEPTH, overflow=1, and out_data shows the new head next cycle.
- OUTPORT_DROP_OLDEST_EN undefined: a write while full with no pop is dropped. FIFO contents and pointers are unchanged, overflow=1, and last_out still updates.

## Test plan
- Reset then idle → out_valid=0, out_data=0x0000, count=0, empty=1, overflow=0, last_out=0x0000.
- Single write 0x1234 with out_ready=0 → next cycle out_valid=1, out_data=0x1234, count=1, last_out=0x1234. Then out_ready=1 for one cycle → empty=1, out_data=0.
- Fill with 0x0001..0x0008 (DEPTH=8) → full=1, count=8. Drain with out_ready held → 0x0001..0x0008 in order, one per cycle, with pointer wrap checked on a second fill.
- Full FIFO, wr_en=1 with 0x00AA and out_ready=1 in the same cycle → count stays 8, overflow stays 0, and 0x00AA exits last.
- Full FIFO (0x0001..0x0008), wr_en=1 with 0x0009 and no pop:
  - without the macro → overflow=1 and the drain yields 0x0001..0x0008;
  - with the macro → overflow=1 and the drain yields 0x0002..0x0009.
  - Then pulse ovf_clr → overflow=0.
- Assert rst low mid-drain with count=5 → out_valid=0 and count=0 immediately. After release, write 0x0F0F → out_data=0x0F0F next cycle.

Source files
------------

// File: rtl/out_port_fifo_if.sv
// Handshake/bus bundle for out_port_fifo: core write side, consumer drain side, status.
// master = core/consumer side, slave = the FIFO.
interface out_port_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] last_out;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             ovf_clr;

  modport master (
    output wr_en, wr_data, out_ready, ovf_clr,
    input  out_valid, out_data, last_out, count, full, empty, overflow
  );

  modport slave (
    input  wr_en, wr_data, out_ready, ovf_clr,
    output out_valid, out_data, last_out, count, full, empty, overflow
  );
endinterface

// File: rtl/out_port_fifo.sv
// Output-port FIFO: queues core OUT writes for a valid/ready consumer, show-ahead head.
// Define OUTPORT_DROP_OLDEST_EN to overwrite the oldest entry on a write while full.
module out_port_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  out_port_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             r_ovf;

  logic w_full, w_empty, w_pop, w_push, w_ovf_wr, w_wr, w_rd;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && bus.out_ready;
  assign w_push   = bus.wr_en && (!w_full || w_pop);
  assign w_ovf_wr = bus.wr_en && w_full && !w_pop;

`ifdef OUTPORT_DROP_OLDEST_EN
  // Overwrite the oldest slot: both pointers advance together, count stays DEPTH.
  assign w_wr = w_push || w_ovf_wr;
  assign w_rd = w_pop  || w_ovf_wr;
`else
  assign w_wr = w_push;
  assign w_rd = w_pop;
`endif

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (bus.wr_en) r_last <= bus.wr_data;
      if (w_ovf_wr)         r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rptr];
  assign bus.last_out  = r_last;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: directed plan steps plus random traffic against a queue model.
module tb_out_port_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  out_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  out_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] m_last = '0;
  logic             m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, ".data"},  32'(bus.out_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk({tag, ".count"}, 32'(bus.count),     32'(q.size()));
    chk({tag, ".full"},  32'(bus.full),      32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(bus.empty),     32'(q.size() == 0));
    chk({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
    chk({tag, ".last"},  32'(bus.last_out),  32'(m_last));
  endtask

  // One clock: apply inputs, advance the model by the behavioural rules, compare.
  task automatic cyc(input logic we, input logic [WIDTH-1:0] wd, input logic rdy,
                     input logic clr, input string tag);
    logic set;
    bus.wr_en = we; bus.wr_data = wd; bus.out_ready = rdy; bus.ovf_clr = clr;
    @(posedge clk);
    set = 1'b0;
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (we) begin
      m_last = wd;
      if (q.size() < DEPTH) q.push_back(wd);
      else begin
        set = 1'b1;
`ifdef OUTPORT_DROP_OLDEST_EN
        void'(q.pop_front());
        q.push_back(wd);
`endif
      end
    end
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    bus.wr_en = 1'b0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
    #12 rst = 1'b1;
    @(posedge clk); #1;
    chk_all("reset");

    cyc(1'b1, 16'h1234, 1'b0, 1'b0, "wr1234");
    chk("wr1234.head", 32'(bus.out_data), 32'h1234);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, "pop1234");
    chk("pop1234.empty", 32'(bus.empty), 32'h1);

    // Two fill/drain rounds so the second exercises pointer wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 16'(i + 16*r), 1'b0, 1'b0, "fill");
      chk("fill.full", 32'(bus.full), 32'h1);
      for (int i = 1; i <= DEPTH; i++) begin
        chk("drain.order", 32'(bus.out_data), 32'(i + 16*r));
        cyc(1'b0, 16'h0, 1'b1, 1'b0, "drain");
      end
    end

    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, "fillaa");
    cyc(1'b1, 16'h00AA, 1'b1, 1'b0, "pushpop_full");
    chk("pushpop_full.ovf", 32'(bus.overflow), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("aa.last_out", 32'(bus.out_data), 32'h00AA);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, "drainaa");
    end

    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, "fillovf");
    cyc(1'b1, 16'h0009, 1'b0, 1'b0, "ovf_wr");
    chk("ovf_wr.ovf", 32'(bus.overflow), 32'h1);
    chk("ovf_wr.last", 32'(bus.last_out), 32'h9);
`ifdef OUTPORT_DROP_OLDEST_EN
    chk("ovf_wr.head", 32'(bus.out_data), 32'h2);
`else
    chk("ovf_wr.head", 32'(bus.out_data), 32'h1);
`endif
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, "drainovf");
    cyc(1'b0, 16'h0, 1'b0, 1'b1, "ovf_clr");
    chk("ovf_clr.ovf", 32'(bus.overflow), 32'h0);

    // Set beats clear in the same cycle.
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, "fillpri");
    cyc(1'b1, 16'h0055, 1'b0, 1'b1, "ovf_pri");
    chk("ovf_pri.ovf", 32'(bus.overflow), 32'h1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, "ovf_clr2");

    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, "drain_to5");
    chk("pre_rst.count", 32'(bus.count), 32'd5);
    #2 rst = 1'b0;
    #1;
    q.delete(); m_last = '0; m_ovf = 1'b0;
    chk_all("async_rst");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 16'h0F0F, 1'b0, 1'b0, "post_rst");
    chk("post_rst.head", 32'(bus.out_data), 32'h0F0F);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, "post_rst_pop");

    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(99) < 60), 16'($urandom), ($urandom_range(99) < 45),
          ($urandom_range(99) < 5), "rand");
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, "final_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
